// File: rtl/lane_dly_step_ctrl.sv
// Lane delay-line step/load sequencer with optional high-speed clock pause.
// Build option: define LANE_DLY_CLK_PAUSE_EN to wrap pulses in PAUSE/SETTLE/RELEASE.
`timescale 1ns/1ps

module lane_dly_step_ctrl #(
   parameter int SETTLE_CYC = 4,
   parameter int STEP_GAP   = 2
) (
   input  logic       FAB_CLK,
   input  logic       RESET,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic       REQ_OP,
   input  logic       REQ_SEL,
   input  logic       REQ_DIR,
   input  logic [7:0] REQ_STEPS,
   output logic       DELAY_LINE_SEL,
   output logic       DELAY_LINE_DIRECTION,
   output logic       DELAY_LINE_LOAD,
   output logic       DELAY_LINE_MOVE,
   output logic       HS_IO_CLK_PAUSE,
   input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
   input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR,
   output logic [7:0] STEPS_DONE
);

   // state      | meaning
   // ST_IDLE    | ready for a command
   // ST_PAUSE   | high-speed clock pause raised
   // ST_SETTLE  | wait SETTLE_CYC before first pulse
   // ST_PULSE   | one MOVE or LOAD pulse
   // ST_GAP     | STEP_GAP idle cycles, range flag sampled on last one
   // ST_RELEASE | pause dropped, wait SETTLE_CYC
   // ST_DONE    | one-cycle completion
   typedef enum logic [2:0] {
      ST_IDLE, ST_PAUSE, ST_SETTLE, ST_PULSE, ST_GAP, ST_RELEASE, ST_DONE
   } state_t;

   localparam logic [3:0] TMR_SETTLE = 4'(SETTLE_CYC - 1);
   localparam logic [3:0] TMR_GAP    = 4'(STEP_GAP - 1);

`ifdef LANE_DLY_CLK_PAUSE_EN
   localparam state_t ST_START = ST_PAUSE;
   localparam state_t ST_END   = ST_RELEASE;
`else
   localparam state_t ST_START = ST_PULSE;
   localparam state_t ST_END   = ST_DONE;
`endif

   state_t     state_q, state_d;
   logic [3:0] tmr_q, tmr_d;
   logic       op_q, op_d, sel_q, sel_d, dir_q, dir_d, err_q, err_d;
   logic [7:0] steps_q, steps_d, cnt_q, cnt_d;
   logic       ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_o_q, err_o_d;
   logic       move_q, move_d, load_q, load_d, pause_q, pause_d;
   logic [7:0] steps_done_q, steps_done_d;
   logic       accept, range_hit;

   always_ff @(posedge FAB_CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         tmr_q        <= '0;
         op_q         <= 1'b0;
         sel_q        <= 1'b0;
         dir_q        <= 1'b0;
         err_q        <= 1'b0;
         steps_q      <= '0;
         cnt_q        <= '0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_o_q      <= 1'b0;
         move_q       <= 1'b0;
         load_q       <= 1'b0;
         pause_q      <= 1'b0;
         steps_done_q <= '0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         op_q         <= op_d;
         sel_q        <= sel_d;
         dir_q        <= dir_d;
         err_q        <= err_d;
         steps_q      <= steps_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_o_q      <= err_o_d;
         move_q       <= move_d;
         load_q       <= load_d;
         pause_q      <= pause_d;
         steps_done_q <= steps_done_d;
      end
   end

   assign accept    = (state_q == ST_IDLE) && REQ_VALID && ready_q;
   assign range_hit = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      op_d    = op_q;
      sel_d   = sel_q;
      dir_d   = dir_q;
      err_d   = err_q;
      steps_d = steps_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d    = REQ_OP;
               sel_d   = REQ_SEL;
               dir_d   = REQ_DIR;
               steps_d = REQ_STEPS;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = (!REQ_OP && REQ_STEPS == 8'd0) ? ST_DONE : ST_START;
            end
         end
         ST_PAUSE: begin
            state_d = ST_SETTLE;
            tmr_d   = TMR_SETTLE;
         end
         ST_SETTLE: begin
            if (tmr_q == 4'd0) state_d = ST_PULSE;
            else               tmr_d   = tmr_q - 4'd1;
         end
         ST_PULSE: begin
            if (!op_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            state_d = ST_GAP;
            tmr_d   = TMR_GAP;
         end
         ST_GAP: begin
            if (tmr_q != 4'd0) begin
               tmr_d = tmr_q - 4'd1;
            end else if (!range_hit && !op_q && cnt_q < steps_q) begin
               state_d = ST_PULSE;
            end else begin
               err_d   = err_q | range_hit;
               state_d = ST_END;
               tmr_d   = TMR_SETTLE;
            end
         end
         ST_RELEASE: begin
            if (tmr_q == 4'd0) state_d = ST_DONE;
            else               tmr_d   = tmr_q - 4'd1;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // handshake outputs follow the next state so READY never overlaps a busy cycle
   always_comb begin
      ready_d      = (state_d == ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_q == ST_DONE);
      err_o_d      = err_q;
      move_d       = (state_q == ST_PULSE) && !op_q;
      load_d       = (state_q == ST_PULSE) && op_q;
      steps_done_d = cnt_q;
`ifdef LANE_DLY_CLK_PAUSE_EN
      pause_d      = (state_q == ST_PAUSE) || (state_q == ST_SETTLE) ||
                     (state_q == ST_PULSE) || (state_q == ST_GAP);
`else
      pause_d      = 1'b0;
`endif
   end

   assign REQ_READY            = ready_q;
   assign BUSY                 = busy_q;
   assign DONE                 = done_q;
   assign ERR                  = err_o_q;
   assign DELAY_LINE_MOVE      = move_q;
   assign DELAY_LINE_LOAD      = load_q;
   assign DELAY_LINE_SEL       = sel_q;
   assign DELAY_LINE_DIRECTION = dir_q;
   assign HS_IO_CLK_PAUSE      = pause_q;
   assign STEPS_DONE           = steps_done_q;

endmodule

// File: tb/tb_lane_dly_step_ctrl.sv
// Directed bench for lane_dly_step_ctrl; expectations follow the build's
// LANE_DLY_CLK_PAUSE_EN setting. Cycle k = k-th rising edge after acceptance.
`timescale 1ns/1ps

module tb_lane_dly_step_ctrl;
   localparam int S = 4;
   localparam int G = 2;
`ifdef LANE_DLY_CLK_PAUSE_EN
   localparam bit PAUSE_ON = 1'b1;
`else
   localparam bit PAUSE_ON = 1'b0;
`endif

   logic       FAB_CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       REQ_VALID = 1'b0, REQ_OP = 1'b0, REQ_SEL = 1'b0, REQ_DIR = 1'b0;
   logic [7:0] REQ_STEPS = '0;
   logic       RX_DELAY_LINE_OUT_OF_RANGE = 1'b0, TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
   logic       REQ_READY, DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
   logic       DELAY_LINE_MOVE, HS_IO_CLK_PAUSE, BUSY, DONE, ERR;
   logic [7:0] STEPS_DONE;

   int total = 0;
   int bad = 0;

   always #5 FAB_CLK = ~FAB_CLK;

   lane_dly_step_ctrl #(.SETTLE_CYC(S), .STEP_GAP(G)) dut (
      .FAB_CLK(FAB_CLK), .RESET(RESET),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
      .REQ_SEL(REQ_SEL), .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
      .DELAY_LINE_SEL(DELAY_LINE_SEL), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
      .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
      .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE),
      .RX_DELAY_LINE_OUT_OF_RANGE(RX_DELAY_LINE_OUT_OF_RANGE),
      .TX_DELAY_LINE_OUT_OF_RANGE(TX_DELAY_LINE_OUT_OF_RANGE),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .STEPS_DONE(STEPS_DONE)
   );

   function automatic int lat(input int n);
      return PAUSE_ON ? 2 + 2*S + n*(1+G) : 1 + n*(1+G);
   endfunction

   function automatic int pfall(input int n);
      return PAUSE_ON ? 2 + S + n*(1+G) : 0;
   endfunction

   // Issues one command and watches it until DONE (bounded); flag_at raises the
   // selected line's range flag once that many MOVE pulses have been seen.
   task automatic run_cmd(input logic op, input logic sel, input logic dir, input int steps,
                          input int flag_at, input bit hold,
                          output int done_cyc, output int n_move, output int n_load,
                          output int p_rise, output int p_fall, output int sd_bad,
                          output int gap_bad, output int ovl, output int rdy_early,
                          output logic err_c1);
      int w, last;
      done_cyc = -1; n_move = 0; n_load = 0; p_rise = 0; p_fall = 0;
      sd_bad = 0; gap_bad = 0; ovl = 0; rdy_early = 0; err_c1 = 1'bx; last = 0;
      w = 0;
      while (REQ_READY !== 1'b1 && w < 100) begin
         @(posedge FAB_CLK); #1; w++;
      end
      REQ_OP = op; REQ_SEL = sel; REQ_DIR = dir; REQ_STEPS = 8'(steps); REQ_VALID = 1'b1;
      @(posedge FAB_CLK); #1;
      if (!hold) REQ_VALID = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge FAB_CLK); #1;
         if (k == 1) err_c1 = ERR;
         if (DELAY_LINE_MOVE === 1'b1 && DELAY_LINE_LOAD === 1'b1) ovl++;
         if (DELAY_LINE_MOVE === 1'b1) begin
            if (last != 0 && k - last != 1 + G) gap_bad++;
            last = k;
            n_move++;
            if (n_move == flag_at) begin
               if (sel) TX_DELAY_LINE_OUT_OF_RANGE = 1'b1;
               else     RX_DELAY_LINE_OUT_OF_RANGE = 1'b1;
            end
         end
         if (DELAY_LINE_LOAD === 1'b1) n_load++;
         if (HS_IO_CLK_PAUSE === 1'b1 && p_rise == 0) p_rise = k;
         if (HS_IO_CLK_PAUSE === 1'b0 && p_rise != 0 && p_fall == 0) p_fall = k;
         if (DELAY_LINE_SEL !== sel || DELAY_LINE_DIRECTION !== dir) sd_bad++;
         if (REQ_READY === 1'b1 && DONE !== 1'b1) rdy_early++;
         if (DONE === 1'b1) begin
            done_cyc = k;
            break;
         end
      end
      RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
      TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
   endtask

   task automatic test_reset();
      logic [16:0] outs;
      repeat (3) @(posedge FAB_CLK);
      #1;
      outs = {REQ_READY, BUSY, DONE, ERR, DELAY_LINE_MOVE, DELAY_LINE_LOAD, HS_IO_CLK_PAUSE,
              DELAY_LINE_SEL, DELAY_LINE_DIRECTION, STEPS_DONE};
      total++;
      if (outs !== 17'd0) begin
         bad++; $display("FAIL reset_outs: got %h want 0", outs);
      end
      RESET = 1'b0;
      @(posedge FAB_CLK); #1;
      total++;
      if (REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
         bad++; $display("FAIL reset_ready: got ready=%b busy=%b want 1/0", REQ_READY, BUSY);
      end
   endtask

   task automatic test_move3();
      int d, nm, nl, pr, pf, sb, gb, ov, re;
      logic e1;
      run_cmd(1'b0, 1'b0, 1'b1, 3, 0, 1'b0, d, nm, nl, pr, pf, sb, gb, ov, re, e1);
      total++; if (d != lat(3)) begin bad++; $display("FAIL move3_done: got %0d want %0d", d, lat(3)); end
      total++; if (nm != 3 || nl != 0) begin bad++; $display("FAIL move3_pulses: got move=%0d load=%0d want 3/0", nm, nl); end
      total++; if (gb != 0) begin bad++; $display("FAIL move3_spacing: got %0d bad gaps want 0", gb); end
      total++; if (pr != (PAUSE_ON ? 1 : 0) || pf != pfall(3)) begin
         bad++; $display("FAIL move3_pause: got rise=%0d fall=%0d want %0d/%0d", pr, pf, PAUSE_ON ? 1 : 0, pfall(3));
      end
      total++; if (sb != 0 || ov != 0) begin bad++; $display("FAIL move3_seldir: got seldir_bad=%0d overlap=%0d want 0/0", sb, ov); end
      total++; if (STEPS_DONE !== 8'd3 || ERR !== 1'b0) begin
         bad++; $display("FAIL move3_status: got steps=%0d err=%b want 3/0", STEPS_DONE, ERR);
      end
   endtask

   task automatic test_abort();
      int d, nm, nl, pr, pf, sb, gb, ov, re;
      logic e1;
      run_cmd(1'b0, 1'b0, 1'b1, 5, 2, 1'b0, d, nm, nl, pr, pf, sb, gb, ov, re, e1);
      total++; if (nm != 2) begin bad++; $display("FAIL abort_pulses: got %0d want 2", nm); end
      total++; if (d != lat(2)) begin bad++; $display("FAIL abort_done: got %0d want %0d", d, lat(2)); end
      total++; if (pf != pfall(2)) begin bad++; $display("FAIL abort_pause: got fall=%0d want %0d", pf, pfall(2)); end
      total++; if (ERR !== 1'b1 || STEPS_DONE !== 8'd2) begin
         bad++; $display("FAIL abort_status: got err=%b steps=%0d want 1/2", ERR, STEPS_DONE);
      end
      repeat (3) @(posedge FAB_CLK);
      #1;
      total++; if (ERR !== 1'b1) begin bad++; $display("FAIL abort_err_hold: got %b want 1", ERR); end
   endtask

   task automatic test_load();
      int d, nm, nl, pr, pf, sb, gb, ov, re;
      logic e1;
      run_cmd(1'b1, 1'b1, 1'b0, 7, 0, 1'b0, d, nm, nl, pr, pf, sb, gb, ov, re, e1);
      total++; if (e1 !== 1'b0) begin bad++; $display("FAIL load_err_clear: got %b want 0", e1); end
      total++; if (nl != 1 || nm != 0) begin bad++; $display("FAIL load_pulses: got load=%0d move=%0d want 1/0", nl, nm); end
      total++; if (d != lat(1)) begin bad++; $display("FAIL load_done: got %0d want %0d", d, lat(1)); end
      total++; if (sb != 0 || STEPS_DONE !== 8'd0 || ERR !== 1'b0) begin
         bad++; $display("FAIL load_status: got seldir_bad=%0d steps=%0d err=%b want 0/0/0", sb, STEPS_DONE, ERR);
      end
   endtask

   task automatic test_sel_tx();
      int d, nm, nl, pr, pf, sb, gb, ov, re;
      logic e1;
      RX_DELAY_LINE_OUT_OF_RANGE = 1'b1;
      run_cmd(1'b0, 1'b1, 1'b0, 2, 0, 1'b0, d, nm, nl, pr, pf, sb, gb, ov, re, e1);
      total++; if (nm != 2 || ERR !== 1'b0) begin bad++; $display("FAIL seltx_ignore_rx: got move=%0d err=%b want 2/0", nm, ERR); end
      total++; if (d != lat(2) || sb != 0) begin bad++; $display("FAIL seltx_done: got %0d sd_bad=%0d want %0d/0", d, sb, lat(2)); end
   endtask

   task automatic test_zero_steps();
      int d, nm, nl, pr, pf, sb, gb, ov, re;
      logic e1;
      run_cmd(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, d, nm, nl, pr, pf, sb, gb, ov, re, e1);
      total++; if (d != 1) begin bad++; $display("FAIL zero_done: got %0d want 1", d); end
      total++; if (pr != 0 || nm != 0 || ERR !== 1'b0) begin
         bad++; $display("FAIL zero_quiet: got pause_rise=%0d move=%0d err=%b want 0/0/0", pr, nm, ERR);
      end
   endtask

   task automatic test_back_to_back();
      int d, nm, nl, pr, pf, sb, gb, ov, re, j;
      logic e1;
      run_cmd(1'b0, 1'b0, 1'b1, 3, 0, 1'b1, d, nm, nl, pr, pf, sb, gb, ov, re, e1);
      total++; if (re != 0 || d != lat(3)) begin
         bad++; $display("FAIL b2b_first: got ready_early=%0d done=%0d want 0/%0d", re, d, lat(3));
      end
      @(posedge FAB_CLK); #1;
      total++; if (BUSY !== 1'b1 || REQ_READY !== 1'b0) begin
         bad++; $display("FAIL b2b_second_start: got busy=%b ready=%b want 1/0", BUSY, REQ_READY);
      end
      REQ_VALID = 1'b0;
      @(posedge FAB_CLK); #1;
      total++; if (STEPS_DONE !== 8'd0) begin bad++; $display("FAIL b2b_steps_clear: got %0d want 0", STEPS_DONE); end
      j = 1;
      while (DONE !== 1'b1 && j < 200) begin
         @(posedge FAB_CLK); #1; j++;
      end
      total++; if (j != lat(3) || STEPS_DONE !== 8'd3) begin
         bad++; $display("FAIL b2b_second_done: got %0d steps=%0d want %0d/3", j, STEPS_DONE, lat(3));
      end
   endtask

   task automatic test_reset_mid();
      int d, nm, nl, pr, pf, sb, gb, ov, re, w, n, rst_k, dones;
      logic e1;
      rst_k = (PAUSE_ON ? 2 + S : 1) + 2 + G;
      w = 0;
      while (REQ_READY !== 1'b1 && w < 100) begin @(posedge FAB_CLK); #1; w++; end
      REQ_OP = 1'b0; REQ_SEL = 1'b0; REQ_DIR = 1'b1; REQ_STEPS = 8'd4; REQ_VALID = 1'b1;
      @(posedge FAB_CLK); #1;
      REQ_VALID = 1'b0;
      n = 0;
      for (int k = 1; k <= rst_k; k++) begin
         @(posedge FAB_CLK); #1;
         if (DELAY_LINE_MOVE === 1'b1) n++;
      end
      total++; if (n != 2 || HS_IO_CLK_PAUSE !== PAUSE_ON) begin
         bad++; $display("FAIL rstmid_pre: got moves=%0d pause=%b want 2/%b", n, HS_IO_CLK_PAUSE, PAUSE_ON);
      end
      RESET = 1'b1;
      #1;
      total++; if ({HS_IO_CLK_PAUSE, DELAY_LINE_MOVE, DELAY_LINE_LOAD, BUSY, DONE} !== 5'd0) begin
         bad++; $display("FAIL rstmid_async: got pause=%b move=%b load=%b busy=%b done=%b want 0",
                         HS_IO_CLK_PAUSE, DELAY_LINE_MOVE, DELAY_LINE_LOAD, BUSY, DONE);
      end
      @(posedge FAB_CLK); @(posedge FAB_CLK); #1;
      RESET = 1'b0;
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge FAB_CLK); #1;
         if (DONE === 1'b1) dones++;
      end
      total++; if (dones != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
      run_cmd(1'b0, 1'b1, 1'b1, 1, 0, 1'b0, d, nm, nl, pr, pf, sb, gb, ov, re, e1);
      total++; if (d != lat(1) || nm != 1) begin
         bad++; $display("FAIL rstmid_next: got done=%0d move=%0d want %0d/1", d, nm, lat(1));
      end
   endtask

   initial begin
      test_reset();
      test_move3();
      test_abort();
      test_load();
      test_sel_tx();
      test_zero_steps();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
